// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame-level sequencer for a 3x3 Laplacian convolution engine.
// Takes a ready/valid pixel stream, drives the engine (pixel, clock-enable, reset),
// flushes the engine pipeline at end of frame, buffers results in a small
// first-word-fall-through FIFO and emits them with start/end-of-frame tags.
// Optional build macro: CONV_CTRL_STATS_EN adds saturating stall counters
// stall_in_cnt / stall_out_cnt (cleared when a new frame starts).
//
// Handshake semantics (both streams): a transfer happens on a rising clk edge
// where valid and ready are both high; valid never depends on ready of the same
// port; data and tags are only meaningful while valid is high.
module conv_frame_ctrl #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int COL_SIZE   = 480,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] in_pixel,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] conv_pixel,
  output logic                 conv_ce,
  output logic                 conv_rst,
  input  logic [WORD_SIZE-1:0] eng_pixel,
  input  logic                 eng_valid,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err
`ifdef CONV_CTRL_STATS_EN
  ,
  output logic [31:0]          stall_in_cnt,
  output logic [31:0]          stall_out_cnt
`endif
);

  localparam int NPIX  = ROW_SIZE * COL_SIZE;
  localparam int EXP   = (ROW_SIZE - 2) * (COL_SIZE - 2);
  localparam int IN_W  = $clog2(NPIX - 1) + 1;
  localparam int RES_W = $clog2(EXP) + 1;
  localparam int FL_W  = $clog2(PIPE_LAT) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [IN_W-1:0]  LAST_IDX = IN_W'(NPIX - 1);
  localparam logic [RES_W-1:0] EXP_CNT  = RES_W'(EXP);
  localparam logic [RES_W-1:0] EOF_CNT  = RES_W'(EXP - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     in_cnt_q, in_cnt_d;
  logic [RES_W-1:0]    res_cnt_q, res_cnt_d;
  logic [RES_W-1:0]    out_cnt_q, out_cnt_d;
  logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic                err_q, err_d;
  logic                frame_done_q, frame_done_d;
  logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic fifo_free;
  logic push;
  logic pop;
  logic drop;
  logic fifo_clr;

  // Output decode from the registered state and FIFO occupancy.
  always_comb begin
    fifo_free  = (fifo_cnt_q != FULL_CNT);
    in_ready   = 1'b0;
    conv_ce    = 1'b0;
    conv_pixel = '0;
    conv_rst   = (state_q == S_IDLE) || (state_q == S_CLR);
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_RUN: begin
        in_ready   = fifo_free;
        conv_ce    = in_valid & fifo_free;
        conv_pixel = in_pixel;
      end
      S_FLUSH: conv_ce = fifo_free;
      default: ;
    endcase
    out_valid = (fifo_cnt_q != '0);
    out_pixel = mem_q[rd_ptr_q];
    out_sof   = out_valid & (out_cnt_q == '0);
    out_eof   = out_valid & (out_cnt_q == EOF_CNT);
    pop       = out_valid & out_ready;
    // Results are only trusted on enabled engine cycles; surplus ones are dropped.
    push      = conv_ce & eng_valid & (res_cnt_q < EXP_CNT);
    drop      = conv_ce & eng_valid & (res_cnt_q == EXP_CNT);
  end

  assign frame_done = frame_done_q;
  assign err        = err_q;

  // Next-state logic for the sequencer, counters and FIFO pointers.
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    err_d        = err_q | drop;
    frame_done_d = pop & out_eof;
    fifo_clr     = 1'b0;
    res_cnt_d    = push ? res_cnt_q + RES_W'(1) : res_cnt_q;
    out_cnt_d    = pop ? out_cnt_q + RES_W'(1) : out_cnt_q;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          err_d   = 1'b0;
        end
      end
      S_CLR: begin
        state_d     = S_RUN;
        in_cnt_d    = '0;
        res_cnt_d   = '0;
        out_cnt_d   = '0;
        flush_cnt_d = '0;
        fifo_clr    = 1'b1;
      end
      S_RUN: begin
        if (conv_ce) begin
          // Position counting ends the frame; in_last is only cross-checked.
          if (in_last != (in_cnt_q == LAST_IDX)) err_d = 1'b1;
          if (in_cnt_q == LAST_IDX) state_d = S_FLUSH;
          else                      in_cnt_d = in_cnt_q + IN_W'(1);
        end
      end
      S_FLUSH: begin
        if (conv_ce) begin
          if (flush_cnt_q == FL_LAST) state_d = S_DRAIN;
          else                        flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      S_DRAIN: begin
        if (res_cnt_q < EXP_CNT) begin
          // Engine delivered too few results: abandon the frame without out_eof.
          err_d    = 1'b1;
          state_d  = S_IDLE;
          fifo_clr = 1'b1;
        end else if (pop & out_eof) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fifo_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
  end

  // State, counter and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      in_cnt_q     <= '0;
      res_cnt_q    <= '0;
      out_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      res_cnt_q    <= res_cnt_d;
      out_cnt_q    <= out_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents are qualified by fifo_cnt_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= eng_pixel;
  end

`ifdef CONV_CTRL_STATS_EN
  logic [31:0] stall_in_cnt_q, stall_in_cnt_d;
  logic [31:0] stall_out_cnt_q, stall_out_cnt_d;

  // Saturating stall counters, restarted when a frame is accepted.
  always_comb begin
    stall_in_cnt_d  = stall_in_cnt_q;
    stall_out_cnt_d = stall_out_cnt_q;
    if (state_q == S_CLR) begin
      stall_in_cnt_d  = '0;
      stall_out_cnt_d = '0;
    end else begin
      if ((state_q == S_RUN) && in_valid && !in_ready && (stall_in_cnt_q != '1))
        stall_in_cnt_d = stall_in_cnt_q + 32'd1;
      if (out_valid && !out_ready && (stall_out_cnt_q != '1))
        stall_out_cnt_d = stall_out_cnt_q + 32'd1;
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_in_cnt_q  <= '0;
      stall_out_cnt_q <= '0;
    end else begin
      stall_in_cnt_q  <= stall_in_cnt_d;
      stall_out_cnt_q <= stall_out_cnt_d;
    end
  end

  assign stall_in_cnt  = stall_in_cnt_q;
  assign stall_out_cnt = stall_out_cnt_q;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: bench for conv_frame_ctrl on a 5x4 frame with a
// behavioural 3x3 Laplacian engine (8-neighbour kernel, clamped to 0..255).
`timescale 1ns/1ps
module tb_conv_frame_ctrl;
  localparam int W     = 8;
  localparam int ROW   = 5;
  localparam int COL   = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int NPIX  = ROW * COL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] in_pixel = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] conv_pixel;
  logic         conv_ce;
  logic         conv_rst;
  logic [W-1:0] eng_pixel;
  logic         eng_valid;
  logic [W-1:0] out_pixel;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_sof;
  logic         out_eof;
  logic         busy;
  logic         frame_done;
  logic         err;
`ifdef CONV_CTRL_STATS_EN
  logic [31:0]  stall_in_cnt;
  logic [31:0]  stall_out_cnt;
`endif

  conv_frame_ctrl #(
    .WORD_SIZE(W), .ROW_SIZE(ROW), .COL_SIZE(COL), .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .conv_pixel(conv_pixel), .conv_ce(conv_ce), .conv_rst(conv_rst),
    .eng_pixel(eng_pixel), .eng_valid(eng_valid),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done), .err(err)
`ifdef CONV_CTRL_STATS_EN
    , .stall_in_cnt(stall_in_cnt), .stall_out_cnt(stall_out_cnt)
`endif
  );

  // ---------------- behavioural engine ----------------
  logic [W-1:0] eng_img [NPIX];
  int           eng_k;
  logic [W-1:0] pipe_px [LAT];
  logic         pipe_v  [LAT];

  assign eng_pixel = pipe_px[LAT-1];
  assign eng_valid = pipe_v[LAT-1];

  // Result whose window has pixel k at its bottom-right corner; bit 8 = valid.
  function automatic logic [8:0] lap(input int k, input logic [W-1:0] cur);
    int r, c, idx, sum, wgt;
    logic [W-1:0] p;
    r = k / ROW;
    c = k % ROW;
    if (k >= NPIX || r < 2 || c < 2) return 9'h000;
    sum = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        idx = (r - 2 + dr) * ROW + (c - 2 + dc);
        p   = (idx == k) ? cur : eng_img[idx];
        wgt = (dr == 1 && dc == 1) ? 8 : -1;
        sum = sum + wgt * int'(p);
      end
    end
    if (sum < 0)   sum = 0;
    if (sum > 255) sum = 255;
    return {1'b1, 8'(sum)};
  endfunction

  always @(posedge clk) begin
    if (conv_rst) begin
      eng_k <= 0;
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i]  <= 1'b0;
        pipe_px[i] <= '0;
      end
    end else if (conv_ce) begin
      if (eng_k < NPIX) eng_img[eng_k] <= conv_pixel;
      {pipe_v[0], pipe_px[0]} <= lap(eng_k, conv_pixel);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_px[i] <= pipe_px[i-1];
      end
      eng_k <= eng_k + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  exp_q [$];
  logic [9:0]  mon_exp;
  logic        pend_done = 1'b0;
  logic [W-1:0] src [NPIX];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: compares every accepted output and the frame_done that follows eof.
  always @(negedge clk) begin
    if (pend_done) begin
      check("frame_done_after_eof", 32'(frame_done), 32'd1);
      check("idle_after_eof", 32'(busy), 32'd0);
      pend_done = 1'b0;
    end else if (rst_n && frame_done) begin
      check("spurious_frame_done", 32'(frame_done), 32'd0);
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'({out_sof, out_eof, out_pixel}), 32'h3ff);
      end else begin
        mon_exp = exp_q.pop_front();
        check("output", 32'({out_sof, out_eof, out_pixel}), 32'(mon_exp));
      end
      if (out_eof) pend_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_pattern(input int p);
    for (int i = 0; i < NPIX; i++) src[i] = (p == 1) ? 8'd10 : 8'd0;
    if (p == 2) src[7] = 8'd255;
    if (p == 3) begin
      src[0]  = 8'd5;
      src[6]  = 8'd20;
      src[13] = 8'd3;
    end
  endtask

  task automatic push_frame(input logic [7:0] e0, e1, e2, e3, e4, e5);
    logic [7:0] e [6];
    e = '{e0, e1, e2, e3, e4, e5};
    for (int i = 0; i < 6; i++) exp_q.push_back({(i == 0), (i == 5), e[i]});
  endtask

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Streams src[0..nstop-1]; in_last at index last_at; start pulsed at start_at.
  task automatic drive_pixels(input int last_at, input int start_at, input int nstop);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < nstop) begin
      in_valid = 1'b1;
      in_pixel = src[i];
      in_last  = (i == last_at);
      start    = (i == start_at);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) i++;
      guard++;
      if (guard > 300) begin
        check("input_timeout", 32'(i), 32'(nstop));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_pixel = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (n >= 200) check("frame_timeout", 32'(busy), 32'd0);
    @(negedge clk);
    check("all_outputs_delivered", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_conv_ce",    32'(conv_ce),    32'd0);
    check("rst_conv_rst",   32'(conv_rst),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_tags",       32'({out_sof, out_eof}), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_conv_pixel", 32'(conv_pixel), 32'd0);

    // Scenario 1: constant 10 -> six zero results
    load_pattern(1);
    push_frame(0, 0, 0, 0, 0, 0);
    start_frame();
    drive_pixels(NPIX - 1, -1, NPIX);
    wait_idle();
    check("s1_err", 32'(err), 32'd0);

    // Scenario 2: lone 255 at row 1, col 2
    load_pattern(2);
    push_frame(0, 255, 0, 0, 0, 0);
    start_frame();
    drive_pixels(NPIX - 1, -1, NPIX);
    wait_idle();
    check("s2_err", 32'(err), 32'd0);

    // Scenario 4: early in_last flags an error but the frame still completes
    load_pattern(1);
    push_frame(0, 0, 0, 0, 0, 0);
    start_frame();
    drive_pixels(12, -1, NPIX);
    wait_idle();
    check("s4_err_set", 32'(err), 32'd1);

    // Scenario 3: downstream stalled for the whole input phase
    out_ready = 1'b0;
    load_pattern(3);
    push_frame(155, 0, 0, 0, 0, 24);
    start_frame();
    @(negedge clk);
    check("s3_err_cleared_by_start", 32'(err), 32'd0);
    drive_pixels(NPIX - 1, -1, NPIX);
    repeat (10) @(negedge clk);
    check("s3_stall_out_valid", 32'(out_valid), 32'd1);
    check("s3_stall_conv_ce",   32'(conv_ce),   32'd0);
    check("s3_stall_in_ready",  32'(in_ready),  32'd0);
    check("s3_stall_busy",      32'(busy),      32'd1);
`ifdef CONV_CTRL_STATS_EN
    check("s3_stall_out_cnt_nz", 32'(stall_out_cnt != 32'd0), 32'd1);
`endif
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();
    check("s3_err", 32'(err), 32'd0);

    // Scenario 5: reset after pixel 9 aborts the frame
    load_pattern(3);
    push_frame(155, 0, 0, 0, 0, 24);
    start_frame();
    drive_pixels(NPIX - 1, -1, 10);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("s5_busy",      32'(busy),      32'd0);
    check("s5_out_valid", 32'(out_valid), 32'd0);
    check("s5_conv_rst",  32'(conv_rst),  32'd1);
    push_frame(155, 0, 0, 0, 0, 24);
    start_frame();
    drive_pixels(NPIX - 1, -1, NPIX);
    wait_idle();
    check("s5_err", 32'(err), 32'd0);

    // Scenario 6: start together with in_valid in IDLE, and again during RUN
    load_pattern(2);
    push_frame(0, 255, 0, 0, 0, 0);
    @(posedge clk); #1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'd99;
    @(negedge clk);
    check("s6_idle_in_ready", 32'(in_ready), 32'd0);
    check("s6_idle_conv_ce",  32'(conv_ce),  32'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("s6_clr_in_ready", 32'(in_ready), 32'd0);
    check("s6_clr_conv_rst", 32'(conv_rst), 32'd1);
    drive_pixels(NPIX - 1, 5, NPIX);
    wait_idle();
    check("s6_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
